// File: rtl/md_sequencer.sv
// Iterative multiply/divide sequencer that owns HI/LO. It takes DATA_W steps per
// operation (shift-add multiply or restoring divide) and stalls dependent front-end requests.
module md_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic              hi_rd,
    input  logic              lo_rd,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              stall
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              state;
    logic                op_div;
    logic                neg_q;
    logic                neg_r;
    logic                div_zero_r;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   p_hi;
    logic [DATA_W-1:0]   p_lo;

    // md_op[0] set means unsigned; only signed ops take magnitudes
    logic                a_neg, b_neg, div_zero;
    logic [DATA_W-1:0]   a_abs, b_abs;
    assign a_neg    = rs_data[DATA_W-1] & ~md_op[0];
    assign b_neg    = rt_data[DATA_W-1] & ~md_op[0];
    assign a_abs    = a_neg ? (~rs_data + 1'b1) : rs_data;
    assign b_abs    = b_neg ? (~rt_data + 1'b1) : rt_data;
    assign div_zero = md_op[1] & (rt_data == '0);

    // Multiply: multiplier sits in p_lo and shifts out LSB-first as the product shifts in
    logic [DATA_W:0]     mul_sum;
    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});

    // Restoring divide: p_hi is the partial remainder, p_lo shifts dividend out / quotient in
    logic [DATA_W:0]     div_sh;
    logic                div_ge;
    logic [DATA_W-1:0]   div_diff;
    assign div_sh   = {p_hi, p_lo[DATA_W-1]};
    assign div_ge   = div_sh >= {1'b0, opnd};
    assign div_diff = div_sh[DATA_W-1:0] - opnd;

    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    assign prod     = {p_hi, p_lo};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign quo_fix  = neg_q ? (~p_lo + 1'b1) : p_lo;
    assign rem_fix  = neg_r ? (~p_hi + 1'b1) : p_hi;

    assign stall = busy & (start | hi_rd | lo_rd | mthi | mtlo);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero_r <= 1'b0;
            cnt        <= '0;
            opnd       <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div     <= md_op[1];
                        neg_q      <= a_neg ^ b_neg;
                        neg_r      <= a_neg;
                        div_zero_r <= div_zero;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        if (div_zero) begin
                            opnd  <= '0;
                            p_hi  <= rs_data;
                            p_lo  <= '0;
                            state <= FIX;
                        end else if (md_op[1]) begin
                            opnd  <= b_abs;
                            p_hi  <= '0;
                            p_lo  <= a_abs;
                            state <= CALC;
                        end else begin
                            opnd  <= a_abs;
                            p_hi  <= '0;
                            p_lo  <= b_abs;
                            state <= CALC;
                        end
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                CALC: begin
                    if (op_div) begin
                        p_hi <= div_ge ? div_diff : div_sh[DATA_W-1:0];
                        p_lo <= {p_lo[DATA_W-2:0], div_ge};
                    end else begin
                        p_hi <= mul_sum[DATA_W:1];
                        p_lo <= {mul_sum[0], p_lo[DATA_W-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W-1)) state <= FIX;
                end
                FIX: begin
                    if (div_zero_r) begin
                        hi <= p_hi;
                        lo <= '1;
                    end else if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: arithmetic results, latency, stall, and reset.
module tb_md_sequencer;
    logic        clock = 1'b0;
    logic        rst_n;
    logic        start, mthi, mtlo, hi_rd, lo_rd;
    logic [1:0]  md_op;
    logic [31:0] rs_data, rt_data;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int errors = 0;
    int checks = 0;

    md_sequencer #(.DATA_W(32)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .md_op(md_op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .hi_rd(hi_rd), .lo_rd(lo_rd), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, return cycles from start edge to done and number of busy samples.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output int nb);
        start = 1'b1; md_op = op; rs_data = a; rt_data = b;
        tick();
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            tick();
            n++;
        end
    endtask

    int n, nb, bad_stall, bad_hi;

    initial begin
        rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        hi_rd = 1'b0; lo_rd = 1'b0; md_op = 2'b00; rs_data = '0; rt_data = '0;
        tick(); tick();
        chk("reset_hi", {32'h0, hi}, 64'h0);
        chk("reset_lo", {32'h0, lo}, 64'h0);
        chk("reset_flags", {61'h0, busy, done, stall}, 64'h0);
        rst_n = 1'b1;
        tick();

        // MULT -3 * 7
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, n, nb);
        chk("mult_latency", 64'(n), 64'd33);
        chk("mult_busy_cycles", 64'(nb), 64'd33);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_done_busy_low", {63'h0, busy}, 64'h0);
        tick();
        chk("mult_done_one_cycle", {63'h0, done}, 64'h0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, nb);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, nb);
        chk("mult_m1_m1", {hi, lo}, 64'h0000_0000_0000_0001);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, n, nb);
        chk("div_neg_latency", 64'(n), 64'd33);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, n, nb);
        chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});

        run_op(2'b11, 32'h0000_1234, 32'd0, n, nb);
        chk("divu_zero_latency", 64'(n), 64'd1);
        chk("divu_zero_busy", 64'(nb), 64'd1);
        chk("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        run_op(2'b10, 32'h8765_4321, 32'd0, n, nb);
        chk("div_zero_signed", {hi, lo}, 64'h8765_4321_FFFF_FFFF);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n, nb);
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

        // MTHI/MTLO in idle
        mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hAAAA_0000;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo", {hi, lo}, 64'hAAAA_0000_AAAA_0000);

        // MULT 2*3 in flight with dependent MFHI, ignored mthi and start
        start = 1'b1; md_op = 2'b00; rs_data = 32'd2; rt_data = 32'd3;
        tick();
        start = 1'b0;
        n = 0; bad_stall = 0; bad_hi = 0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (n == 2) hi_rd = 1'b1;
            if (n == 4) begin mthi = 1'b1; rs_data = 32'h5555_5555; end
            if (n == 5) mthi = 1'b0;
            if (n == 6) begin start = 1'b1; md_op = 2'b11; rs_data = 32'd1; rt_data = 32'd0; end
            if (n == 7) start = 1'b0;
            #1;
            if (!done && n >= 2 && stall !== 1'b1) bad_stall++;
            if (!done && hi !== 32'hAAAA_0000) bad_hi++;
        end
        chk("stall_latency", 64'(n), 64'd33);
        chk("stall_while_busy", 64'(bad_stall), 64'd0);
        chk("hi_old_while_busy", 64'(bad_hi), 64'd0);
        chk("stall_released_done", {63'h0, stall}, 64'h0);
        chk("mult_2_3", {hi, lo}, {32'd0, 32'd6});
        hi_rd = 1'b0;
        tick();
        chk("busy_start_ignored", {63'h0, busy}, 64'h0);
        chk("busy_mthi_ignored", {32'h0, hi}, 64'h0);

        // Asynchronous reset mid-divide
        start = 1'b1; md_op = 2'b10; rs_data = 32'd100; rt_data = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        hi_rd = 1'b1;
        #1;
        chk("pre_reset_busy", {63'h0, busy}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_hilo", {hi, lo}, 64'h0);
        chk("async_reset_flags", {61'h0, busy, done, stall}, 64'h0);
        hi_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_op(2'b01, 32'd3, 32'd5, n, nb);
        chk("post_reset_latency", 64'(n), 64'd33);
        chk("post_reset_multu", {hi, lo}, {32'd0, 32'd15});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
